ahb_lite_slave_mem: RTL and testbench

AHB-Lite slave with a word-organised internal memory. It is the transfer-consuming stage behind the AHB master/driver and uses the package encodings for HTRANS, HBURST, HSIZE and HRESP (OKAY=2'b00, ERROR=2'b01). Its features are:
- programmable wait states;
- byte/halfword/word writes;
- SEQ-address continuity checking for INCRx/WRAPx bursts;
- two-cycle ERROR responses.

---
 rtl/ahb_lite_slave_mem_if.sv | 28 ++
 rtl/ahb_lite_slave_mem.sv | 174 +++++++++++++++++
 tb/tb_ahb_lite_slave_mem.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and the word-organised memory slave.
// HREADY is the bus-level ready that the interconnect feeds back to every slave.
interface ahb_lite_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: programmable wait states, byte-lane writes, SEQ continuity
// checking for INCR/WRAP bursts and two-cycle ERROR responses.
module ahb_lite_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic                 HCLK,
  input logic                 HRESET,
  ahb_lite_slave_mem_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH) << 2;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_SEQ  = 2'b11;
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
  localparam logic [2:0] BU_WRAP4  = 3'b010;
  localparam logic [2:0] BU_WRAP8  = 3'b100;
  localparam logic [2:0] BU_WRAP16 = 3'b110;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e                  state_q;
  logic                    hreadyout_q;
  logic [1:0]              hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;
  logic [2:0]              wait_cnt_q;
  logic                    burst_active_q;

  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [2:0]              hsize_q;
  logic [2:0]              hburst_q;
  logic                    write_q;
  logic [IDX_W-1:0]        idx_q;
  logic [3:0]              be_q;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << a;
      SZ_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [3:0] be);
    merge = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  function automatic state_e next_on_accept(input logic err);
    if (err)                  next_on_accept = S_ERR1;
    else if (WAIT_STATES > 0) next_on_accept = S_WAIT;
    else                      next_on_accept = S_DATA;
  endfunction

  // Expected next SEQ address, derived from the previously accepted beat.
  logic [ADDR_WIDTH-1:0] inc_d, wrap_mask_d, lin_addr_d, exp_addr_d;
  logic [4:0]            beats_d;
  always_comb begin
    beats_d = 5'd0;
    case (hburst_q)
      BU_WRAP4:  beats_d = 5'd4;
      BU_WRAP8:  beats_d = 5'd8;
      BU_WRAP16: beats_d = 5'd16;
      default:   beats_d = 5'd0;
    endcase
    inc_d       = ADDR_WIDTH'(1) << hsize_q;
    wrap_mask_d = (ADDR_WIDTH'(beats_d) << hsize_q) - ADDR_WIDTH'(1);
    lin_addr_d  = haddr_q + inc_d;
    exp_addr_d  = (beats_d != 5'd0) ? ((haddr_q & ~wrap_mask_d) | (lin_addr_d & wrap_mask_d))
                                    : lin_addr_d;
  end

  logic                  can_accept_d, accept_d, err_d;
  logic [ADDR_WIDTH:0]   off_d;
  logic [IDX_W-1:0]      idx_d, rd_idx_d;
  logic [DATA_WIDTH-1:0] rd_word_d;

  assign can_accept_d = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept_d     = can_accept_d && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  // The extra MSB is the borrow, flagging addresses below BASE_ADDR.
  assign off_d        = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign idx_d        = off_d[IDX_W+1:2];
  assign err_d = (bus.HSIZE > SZ_WORD)
              || ((bus.HSIZE == SZ_HALF) && bus.HADDR[0])
              || ((bus.HSIZE == SZ_WORD) && (bus.HADDR[1:0] != 2'b00))
              || off_d[ADDR_WIDTH] || (off_d[ADDR_WIDTH-1:0] >= MEM_BYTES)
              || ((bus.HTRANS == TR_SEQ) && (!burst_active_q || (bus.HADDR != exp_addr_d)));

  // A read entering DATA right behind a write DATA to the same word sees the new bytes.
  assign rd_idx_d  = (state_q == S_WAIT) ? idx_q : idx_d;
  assign rd_word_d = ((state_q == S_DATA) && write_q && (idx_q == rd_idx_d))
                   ? merge(mem_q[rd_idx_d], bus.HWDATA, be_q) : mem_q[rd_idx_d];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q        <= S_IDLE;
      hreadyout_q    <= 1'b1;
      hresp_q        <= RESP_OKAY;
      hrdata_q       <= '0;
      wait_cnt_q     <= '0;
      burst_active_q <= 1'b0;
    end else begin
      hrdata_q <= '0;
      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q <= 3'd1) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            if (!write_q) hrdata_q <= rd_word_d;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_ERROR;
        end
        default: begin
          if (accept_d) begin
            state_q        <= next_on_accept(err_d);
            hreadyout_q    <= (next_on_accept(err_d) == S_DATA);
            hresp_q        <= err_d ? RESP_ERROR : RESP_OKAY;
            wait_cnt_q     <= 3'(WAIT_STATES);
            burst_active_q <= !err_d;
            if ((next_on_accept(err_d) == S_DATA) && !bus.HWRITE) hrdata_q <= rd_word_d;
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            // BUSY keeps the burst alive; IDLE or a deselect ends it.
            if (bus.HREADY && (!bus.HSEL || (bus.HTRANS == TR_IDLE))) burst_active_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept_d) begin
      haddr_q  <= bus.HADDR;
      hsize_q  <= bus.HSIZE;
      hburst_q <= bus.HBURST;
      write_q  <= bus.HWRITE;
      idx_q    <= idx_d;
      be_q     <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q)
      mem_q[idx_q] <= merge(mem_q[idx_q], bus.HWDATA, be_q);
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: three slaves (0, 3 and 2 wait states) behind a simple
// decoder; a pipelined driver pushes expected responses, a negedge monitor checks them.
module tb_ahb_lite_slave_mem;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_WRAP4 = 3'b010, B_INCR4 = 3'b011;
  localparam logic [2:0] Z_B = 3'b000, Z_H = 3'b001, Z_W = 3'b010, Z_D = 3'b011;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  int              sel;
  logic            hsel;
  logic [AW-1:0]   haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize, hburst;
  logic [DW-1:0]   hwdata;
  logic            hready_mux;
  logic [1:0]      hresp_mux;
  logic [DW-1:0]   hrdata_mux;

  ahb_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ahb_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  ahb_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus0.HSEL = hsel && (sel == 0);  assign bus1.HSEL = hsel && (sel == 1);
  assign bus2.HSEL = hsel && (sel == 2);
  assign bus0.HADDR = haddr;   assign bus1.HADDR = haddr;   assign bus2.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;   assign bus1.HSIZE = hsize;   assign bus2.HSIZE = hsize;
  assign bus0.HBURST = hburst; assign bus1.HBURST = hburst; assign bus2.HBURST = hburst;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
  assign bus0.HREADY = hready_mux; assign bus1.HREADY = hready_mux;
  assign bus2.HREADY = hready_mux;

  always_comb begin
    case (sel)
      1:       begin hready_mux = bus1.HREADYOUT; hresp_mux = bus1.HRESP; hrdata_mux = bus1.HRDATA; end
      2:       begin hready_mux = bus2.HREADYOUT; hresp_mux = bus2.HRESP; hrdata_mux = bus2.HRDATA; end
      default: begin hready_mux = bus0.HREADYOUT; hresp_mux = bus0.HRESP; hrdata_mux = bus0.HRDATA; end
    endcase
  end

  ahb_lite_slave_mem #(.WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0));
  ahb_lite_slave_mem #(.WAIT_STATES(3)) dut1 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus1));
  ahb_lite_slave_mem #(.WAIT_STATES(2)) dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2));

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic [1:0]  resp;
    int          waits;
    logic [31:0] rdata;
  } xfer_t;

  typedef struct {
    logic [1:0]  resp;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  xfer_t seq_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s (sel %0d): got %h, expected %h", nm, sel, act, expv);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [2:0] z, input logic [2:0] b, input logic [31:0] wd,
                     input logic [1:0] rs, input int wt, input logic [31:0] rd);
    xfer_t x;
    x.trans = t; x.addr = a; x.wr = w; x.size = z; x.burst = b; x.wdata = wd;
    x.resp = rs; x.waits = wt; x.rdata = rd;
    seq_q.push_back(x);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int ws);
    add(T_NSEQ, a, 1'b1, Z_W, B_SINGLE, d, OKAY, ws, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input int ws);
    add(T_NSEQ, a, 1'b0, Z_W, B_SINGLE, 32'h0, OKAY, ws, d);
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge HCLK);
    while (!hready_mux && t < 40) begin
      @(negedge HCLK);
      t++;
    end
    if (!hready_mux) begin
      vectors++;
      miscompares++;
      $display("FAIL hready timeout (sel %0d): got 0, expected 1 within 40 cycles", sel);
    end
  endtask

  // Drives the queued vectors back-to-back with AHB address/data pipelining.
  task automatic run_seq();
    int n = seq_q.size();
    exp_t e;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        htrans = seq_q[k].trans; haddr = seq_q[k].addr; hwrite = seq_q[k].wr;
        hsize = seq_q[k].size; hburst = seq_q[k].burst;
        if (seq_q[k].trans[1]) begin
          e.resp = seq_q[k].resp; e.waits = seq_q[k].waits; e.rdata = seq_q[k].rdata;
          exp_q.push_back(e);
        end
      end else begin
        htrans = T_IDLE; hwrite = 1'b0;
      end
      wait_ready();
      @(posedge HCLK); #1;
      if (k < n) hwdata = seq_q[k].wdata;
    end
    wait_ready();
    @(posedge HCLK); #1;
    seq_q.delete();
  endtask

  logic dp_active = 1'b0;
  int   low_cnt = 0;
  exp_t cur;

  always @(negedge HCLK) begin
    if (!mon_en) begin
      dp_active = 1'b0;
      low_cnt = 0;
    end else begin
      if (dp_active) begin
        if (!hready_mux) begin
          low_cnt++;
          chk("wait-cycle HRDATA", hrdata_mux, 32'h0);
          if (exp_q.size() > 0) chk("wait-cycle HRESP", 32'(hresp_mux), 32'(exp_q[0].resp));
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard (sel %0d): got a completion, expected none pending", sel);
        end else begin
          cur = exp_q.pop_front();
          chk("HRESP", 32'(hresp_mux), 32'(cur.resp));
          chk("wait cycles", 32'(low_cnt), 32'(cur.waits));
          chk("HRDATA", hrdata_mux, cur.rdata);
        end
      end else begin
        chk("idle HREADYOUT", 32'(hready_mux), 32'h1);
        chk("idle HRESP", 32'(hresp_mux), 32'(OKAY));
        chk("idle HRDATA", hrdata_mux, 32'h0);
      end
      if (hready_mux) begin
        dp_active = hsel && htrans[1];
        low_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    sel = 0; hsel = 1'b1; htrans = T_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = Z_W; hburst = B_SINGLE; hwdata = '0; HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset HREADYOUT", 32'(hready_mux), 32'h1);
      chk("reset HRESP", 32'(hresp_mux), 32'(OKAY));
      chk("reset HRDATA", hrdata_mux, 32'h0);
    end
    sel = 0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    mon_en = 1'b1;

    // Zero wait states: write then pipelined read of the same word.
    wr(32'h10, 32'hDEADBEEF, 0); rd(32'h10, 32'hDEADBEEF, 0);
    run_seq();
    // Byte and halfword lanes over a cleared word.
    wr(32'h20, 32'h0, 0);
    add(T_NSEQ, 32'h21, 1'b1, Z_B, B_SINGLE, 32'hFFFFA5FF, OKAY, 0, 32'h0);
    rd(32'h20, 32'h0000A500, 0);
    add(T_NSEQ, 32'h22, 1'b1, Z_H, B_SINGLE, 32'h1234FFFF, OKAY, 0, 32'h0);
    rd(32'h20, 32'h1234A500, 0);
    run_seq();
    // Seeds, then a legal WRAP4 read starting at 0x38.
    wr(32'h00, 32'h11111100, 0); wr(32'h08, 32'h22222208, 0);
    wr(32'h30, 32'h33330030, 0); wr(32'h34, 32'h33330034, 0);
    wr(32'h38, 32'h33330038, 0); wr(32'h3C, 32'h3333003C, 0);
    wr(32'h40, 32'h44440040, 0);
    add(T_NSEQ, 32'h38, 1'b0, Z_W, B_WRAP4, 32'h0, OKAY, 0, 32'h33330038);
    add(T_SEQ,  32'h3C, 1'b0, Z_W, B_WRAP4, 32'h0, OKAY, 0, 32'h3333003C);
    add(T_SEQ,  32'h30, 1'b0, Z_W, B_WRAP4, 32'h0, OKAY, 0, 32'h33330030);
    add(T_SEQ,  32'h34, 1'b0, Z_W, B_WRAP4, 32'h0, OKAY, 0, 32'h33330034);
    run_seq();
    // WRAP4 write whose third beat breaks the wrap: 0x40 instead of 0x30.
    add(T_NSEQ, 32'h38, 1'b1, Z_W, B_WRAP4, 32'hAAAA0038, OKAY, 0, 32'h0);
    add(T_SEQ,  32'h3C, 1'b1, Z_W, B_WRAP4, 32'hAAAA003C, OKAY, 0, 32'h0);
    add(T_SEQ,  32'h40, 1'b1, Z_W, B_WRAP4, 32'hEEEEEEEE, ERROR, 1, 32'h0);
    run_seq();
    rd(32'h38, 32'hAAAA0038, 0); rd(32'h3C, 32'hAAAA003C, 0);
    rd(32'h40, 32'h44440040, 0); rd(32'h30, 32'h33330030, 0);
    run_seq();
    // Out of range, misaligned, oversize, SEQ without a live burst.
    add(T_NSEQ, 32'h400, 1'b1, Z_W, B_SINGLE, 32'hBADBAD00, ERROR, 1, 32'h0);
    add(T_NSEQ, 32'h02,  1'b1, Z_W, B_SINGLE, 32'hBADBAD02, ERROR, 1, 32'h0);
    add(T_NSEQ, 32'h08,  1'b1, Z_D, B_SINGLE, 32'hBADBAD08, ERROR, 1, 32'h0);
    add(T_SEQ,  32'h10,  1'b0, Z_W, B_INCR,   32'h0,        ERROR, 1, 32'h0);
    run_seq();
    rd(32'h00, 32'h11111100, 0); rd(32'h08, 32'h22222208, 0); rd(32'h10, 32'hDEADBEEF, 0);
    run_seq();
    // INCR burst with a BUSY beat in the middle.
    add(T_NSEQ, 32'h60, 1'b1, Z_W, B_INCR, 32'h60606060, OKAY, 0, 32'h0);
    add(T_BUSY, 32'h64, 1'b1, Z_W, B_INCR, 32'h0, OKAY, 0, 32'h0);
    add(T_SEQ,  32'h64, 1'b1, Z_W, B_INCR, 32'h64646464, OKAY, 0, 32'h0);
    rd(32'h60, 32'h60606060, 0); rd(32'h64, 32'h64646464, 0);
    run_seq();

    // Three wait states: seeded INCR4 read, then an error keeps its two-cycle length.
    sel = 1;
    wr(32'h40, 32'h51510040, 3); wr(32'h44, 32'h51510044, 3);
    wr(32'h48, 32'h51510048, 3); wr(32'h4C, 32'h5151004C, 3);
    run_seq();
    add(T_NSEQ, 32'h40, 1'b0, Z_W, B_INCR4, 32'h0, OKAY, 3, 32'h51510040);
    add(T_SEQ,  32'h44, 1'b0, Z_W, B_INCR4, 32'h0, OKAY, 3, 32'h51510044);
    add(T_SEQ,  32'h48, 1'b0, Z_W, B_INCR4, 32'h0, OKAY, 3, 32'h51510048);
    add(T_SEQ,  32'h4C, 1'b0, Z_W, B_INCR4, 32'h0, OKAY, 3, 32'h5151004C);
    add(T_NSEQ, 32'h400, 1'b1, Z_W, B_SINGLE, 32'hBADBAD00, ERROR, 1, 32'h0);
    run_seq();

    // Two wait states: reset lands while a write is still waiting.
    sel = 2;
    wr(32'h50, 32'hCAFEF00D, 2);
    run_seq();
    mon_en = 1'b0;
    htrans = T_NSEQ; haddr = 32'h50; hwrite = 1'b1; hsize = Z_W; hburst = B_SINGLE;
    wait_ready();
    @(posedge HCLK); #1;
    hwdata = 32'h12345678; htrans = T_IDLE; hwrite = 1'b0;
    @(posedge HCLK); #1;
    chk("pre-reset WAIT HREADYOUT", 32'(hready_mux), 32'h0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    chk("post-reset HREADYOUT", 32'(hready_mux), 32'h1);
    chk("post-reset HRESP", 32'(hresp_mux), 32'(OKAY));
    chk("post-reset HRDATA", hrdata_mux, 32'h0);
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    rd(32'h50, 32'hCAFEF00D, 2);
    run_seq();
    repeat (3) @(posedge HCLK);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
